prioritized_arbiter_input_queue: RTL and testbench
==================================================

Name: prioritized_arbiter_input_queue

Overview:
- Upstream buffering stage for prioritized_arbiter_behavor.
- Holds one small FIFO per input channel.
- Presents each FIFO head as data[i] and selection[i] (head valid) to the arbiter.
- Pops a FIFO when downstream logic returns a grant bit for that channel, so producers are decoupled from arbitration outcome.

Parameters:
- data_width, 8, width of one data word.
- number_of_inputs, 4, number of independent input channels; matches the arbiter.
- queue_depth, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  [data_width-1:0] x number_of_inputs  producer write data per channel.
- in_valid  input  1 x number_of_inputs  producer write request per channel.
- in_ready  output  1 x number_of_inputs  channel can accept a word this cycle.
- data  output  [data_width-1:0] x number_of_inputs  FIFO head per channel; feeds arbiter data.
- selection  output  1 x number_of_inputs  FIFO non-empty per channel; feeds arbiter selection.
- grant  input  [number_of_inputs-1:0]  bit i = head of channel i consumed this cycle.
- grant_error  output  1  sticky; set on any grant to an empty channel.

Behaviour:
- Reset (rst=1 at clk edge):
  - All read/write pointers and occupancy counts go to 0.
  - selection = all 0; grant_error = 0; data = all 0.
  - in_ready = all 0 while rst is high; all 1 from the first cycle after rst deasserts.
  - Storage array is not reset.
- Channels are fully independent; one FIFO per channel, no shared state except grant_error.
- Push on channel i: in_valid[i] && in_ready[i] at the clk edge; writes in_data[i] at the write pointer, advances the pointer, count +1.
- Pop on channel i: grant[i] && selection[i] at the clk edge; advances the read pointer, count -1.
- in_ready[i] = (count_i != queue_depth).
  - Combinational from the registered count only; it does not depend on same-cycle grant.
  - A full channel therefore refuses a push even when it is popped in the same cycle.
- selection[i] = (count_i != 0). data[i] = storage[rd_ptr_i] when non-empty, else all-zero (masked for a deterministic arbiter input).
- Latency: a word pushed at edge N is visible on data/selection after edge N; no write-through bypass when empty.
- Simultaneous push and pop on a non-full, non-empty channel: both take effect; count unchanged; FIFO order preserved.
- Pointers are log2(queue_depth) bits and wrap naturally modulo queue_depth. Count is log2(queue_depth)+1 bits, range 0..queue_depth.
- grant[i] while selection[i]=0:
  - Ignored; no pointer or count change.
  - grant_error is set and held until rst.
- Multiple grant bits set in one cycle: each channel is popped independently. Not an error; the arbiter normally grants one-hot.
- in_valid[i] while in_ready[i]=0: the word is dropped; the producer is required to hold it (standard valid/ready). Not flagged.
- Reset mid-operation: all queued words are discarded; the next cycle shows an empty state.
- No output combinationally depends on in_data or in_valid. in_ready depends only on state.

Decomposition:
- Shared package prioritized_arbiter_pkg:
  - default constants DEFAULT_DATA_WIDTH=8, DEFAULT_NUMBER_OF_INPUTS=4, DEFAULT_QUEUE_DEPTH=4;
  - the default priority list {3,1,2,0}, so queue and arbiter instances agree on defaults;
  - a helper function for pointer width (clog2 of depth).
- One sub-module: prioritized_arbiter_fifo.
  - Single-channel synchronous FIFO with push/pop, count, full/empty, masked head.
  - Instantiated number_of_inputs times in a generate loop.
  - The top level only wires the FIFOs and ORs the per-channel grant-to-empty pulses into the sticky grant_error.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on channel 2 (grant=0) -> after the third edge selection=4'b0100, data[2]=0x11, in_ready[2]=1; grant=4'b0100 for 3 cycles -> data[2] reads 0x22, 0x33, then selection[2]=0 and data[2]=0x00.
- Fill channel 0 with 0xA0..0xA3 (depth 4) -> in_ready[0]=0; push 0xA4 with grant[0]=1 in the same cycle -> 0xA4 not stored, count 3, data[0]=0xA1, in_ready[0]=1 next cycle.
- Channel 1 holding 1 word, push 0x55 and grant[1]=1 in the same cycle -> count stays 1, data[1]=0x55.
- 10 push/pop pairs on channel 3 with values 0..9 -> output order 0..9 across pointer wrap, with no loss or duplication.
- grant=4'b0010 with channel 1 empty -> no state change, grant_error=1 and stays 1; rst -> grant_error=0.
- Load all four channels, assert rst for 1 cycle -> selection=0 and data all 0x00 next cycle; in_ready=0 during rst, 4'b1111 after.

Source files
------------

// File: rtl/prioritized_arbiter_pkg.sv
// Shared defaults for the prioritized arbiter and its input queue. Both blocks
// import these values so that their default instances agree.
//   DEFAULT_DATA_WIDTH       width of one data word
//   DEFAULT_NUMBER_OF_INPUTS number of arbitrated channels
//   DEFAULT_QUEUE_DEPTH      entries per channel FIFO (power of two, >= 2)
//   DEFAULT_PRIORITY         channel priority list, highest first
//   ptr_width()              FIFO pointer width for a given depth
package prioritized_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH       = 8;
  localparam int DEFAULT_NUMBER_OF_INPUTS = 4;
  localparam int DEFAULT_QUEUE_DEPTH      = 4;

  localparam int DEFAULT_PRIORITY [DEFAULT_NUMBER_OF_INPUTS] = '{3, 1, 2, 0};

  // Pointer width for a FIFO of the given depth. It never returns less than
  // one bit, so that a degenerate depth still elaborates.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/prioritized_arbiter_fifo.sv
// Single-channel synchronous FIFO that feeds one arbiter input.
//   clk, rst     clock and synchronous active-high reset (control state only)
//   push_data    write word
//   push_valid   write request
//   push_ready   space available; low while rst is high
//   pop          consume request (the arbiter grant bit)
//   head         word at the read pointer, forced to zero when empty
//   head_valid   FIFO non-empty
//   pop_err      pulse: pop requested while empty
module prioritized_arbiter_fifo
  import prioritized_arbiter_pkg::*;
#(
  parameter int data_width  = DEFAULT_DATA_WIDTH,
  parameter int queue_depth = DEFAULT_QUEUE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] push_data,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic                  head_valid,
  output logic                  pop_err
);

  localparam int PW = ptr_width(queue_depth);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(queue_depth);

  logic [data_width-1:0] mem [queue_depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // Readiness uses the registered count only; a same-cycle pop does not make
  // room, so a full FIFO refuses a push even while it is being drained.
  assign push_ready = !rst && !full;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_err    = pop && empty;

  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head mask hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prioritized_arbiter_input_queue.sv
// Input buffering stage for the prioritized arbiter: one FIFO per channel,
// popped by the arbiter's grant so producers never see arbitration outcome.
//   clk, rst     clock and synchronous active-high reset
//   in_data      producer write data per channel
//   in_valid     producer write request per channel
//   in_ready     channel can accept a word this cycle (low during rst)
//   data         FIFO head per channel, zero when empty
//   selection    FIFO non-empty per channel
//   grant        bit i consumes the head of channel i this cycle
//   grant_error  sticky flag: a grant hit an empty channel since reset
module prioritized_arbiter_input_queue
  import prioritized_arbiter_pkg::*;
#(
  parameter int data_width       = DEFAULT_DATA_WIDTH,
  parameter int number_of_inputs = DEFAULT_NUMBER_OF_INPUTS,
  parameter int queue_depth      = DEFAULT_QUEUE_DEPTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [number_of_inputs-1:0][data_width-1:0] in_data,
  input  logic [number_of_inputs-1:0]                 in_valid,
  output logic [number_of_inputs-1:0]                 in_ready,
  output logic [number_of_inputs-1:0][data_width-1:0] data,
  output logic [number_of_inputs-1:0]                 selection,
  input  logic [number_of_inputs-1:0]                 grant,
  output logic                                        grant_error
);

  logic [number_of_inputs-1:0] empty_grant;

  for (genvar i = 0; i < number_of_inputs; i++) begin : g_chan
    prioritized_arbiter_fifo #(
      .data_width  (data_width),
      .queue_depth (queue_depth)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_data  (in_data[i]),
      .push_valid (in_valid[i]),
      .push_ready (in_ready[i]),
      .pop        (grant[i]),
      .head       (data[i]),
      .head_valid (selection[i]),
      .pop_err    (empty_grant[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)               grant_error <= 1'b0;
    else if (|empty_grant) grant_error <= 1'b1;
  end

endmodule

// File: tb/tb_prioritized_arbiter_input_queue.sv
module tb_prioritized_arbiter_input_queue;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [3:0][7:0] data;
  logic [3:0]      selection;
  logic [3:0]      grant;
  logic            grant_error;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: per-channel queue of expected words, plus expected error flag.
  logic [7:0] mq [4][$];
  logic       err_m;

  always #5 clk = ~clk;

  prioritized_arbiter_input_queue dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data        (data),
    .selection   (selection),
    .grant       (grant),
    .grant_error (grant_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every channel against the scoreboard.
  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sel[%0d]", i), 32'(selection[i]), 32'(mq[i].size() != 0));
      chk($sformatf("data[%0d]", i), 32'(data[i]),
          (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'h0);
      chk($sformatf("rdy[%0d]", i), 32'(in_ready[i]), 32'(!rst && mq[i].size() < 4));
    end
    chk("grant_error", 32'(grant_error), 32'(err_m));
  endtask

  // One clock: decide push/pop from the pre-edge model, advance, then check.
  task automatic tick();
    logic [3:0] acc, pop;
    for (int i = 0; i < 4; i++) begin
      acc[i] = in_valid[i] && !rst && (mq[i].size() < 4);
      pop[i] = grant[i] && (mq[i].size() != 0);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      err_m = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (grant[i] && mq[i].size() == 0) err_m = 1'b1;
        if (pop[i]) void'(mq[i].pop_front());
        if (acc[i]) mq[i].push_back(in_data[i]);
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = '0;
    grant    = '0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; err_m = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_sel", 32'(selection), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'hF);

    // Channel 2: three pushes, then three grants.
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0100;
      in_data[2] = 8'h11 * 8'(k + 1);
      tick();
    end
    idle();
    chk("ch2_sel", 32'(selection), 32'h4);
    chk("ch2_head", 32'(data[2]), 32'h11);
    chk("ch2_ready", 32'(in_ready[2]), 32'h1);
    grant = 4'b0100;
    tick(); chk("ch2_pop1", 32'(data[2]), 32'h22);
    tick(); chk("ch2_pop2", 32'(data[2]), 32'h33);
    tick(); chk("ch2_empty_sel", 32'(selection[2]), 32'h0);
    chk("ch2_empty_data", 32'(data[2]), 32'h0);
    idle();

    // Channel 0: fill, then push into full while popping.
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0001;
      in_data[0] = 8'hA0 + 8'(k);
      tick();
    end
    chk("ch0_full_ready", 32'(in_ready[0]), 32'h0);
    in_valid = 4'b0001; in_data[0] = 8'hA4; grant = 4'b0001;
    tick();
    idle();
    chk("ch0_head_after", 32'(data[0]), 32'hA1);
    chk("ch0_ready_after", 32'(in_ready[0]), 32'h1);

    // Channel 1: one word, then simultaneous push and pop.
    in_valid = 4'b0010; in_data[1] = 8'h44;
    tick();
    in_valid = 4'b0010; in_data[1] = 8'h55; grant = 4'b0010;
    tick();
    idle();
    chk("ch1_pp_data", 32'(data[1]), 32'h55);
    chk("ch1_pp_sel", 32'(selection[1]), 32'h1);
    grant = 4'b0010;
    tick();
    idle();

    // Channel 3: ten push/pop pairs across pointer wrap.
    in_valid = 4'b1000; in_data[3] = 8'd0;
    tick();
    for (int k = 1; k < 10; k++) begin
      in_valid = 4'b1000; in_data[3] = 8'(k); grant = 4'b1000;
      tick();
      chk($sformatf("ch3_order%0d", k), 32'(data[3]), 32'(k));
    end
    in_valid = '0; grant = 4'b1000;
    tick();
    idle();
    chk("ch3_drained", 32'(selection[3]), 32'h0);

    // Drain channel 0, then grant an empty channel.
    grant = 4'b0001;
    repeat (3) tick();
    grant = 4'b0010;
    tick();
    idle();
    chk("gerr_set", 32'(grant_error), 32'h1);
    chk("gerr_nochange", 32'(selection), 32'h0);
    tick();
    chk("gerr_hold", 32'(grant_error), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("gerr_clear", 32'(grant_error), 32'h0);

    // Load every channel, then reset mid-operation.
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'b1111;
      for (int i = 0; i < 4; i++) in_data[i] = 8'(8'h80 + 8'(i * 16 + k));
      tick();
    end
    idle();
    chk("load_sel", 32'(selection), 32'hF);
    rst = 1'b1;
    tick();
    chk("mid_rst_sel", 32'(selection), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    tick();
    chk("after_rst_ready", 32'(in_ready), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
